// File: rtl/tdm_pkg.sv
// tdm_pkg: shared defaults, lock state and miss counter width for the TDM demux
package tdm_pkg;
  localparam int N_CH_DEF = 4;
  localparam int SEL_W_DEF = 2;
  localparam int MISS_W = 3;
  typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index tracker with realign-to-1 and clear
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] slot,
  output logic             wrap
);
  assign wrap = en && slot == SEL_W'(N_CH - 1);
  always_ff @(posedge clk)
    slot <= (rst || clr) ? '0 : load1 ? SEL_W'(1) : en ? slot + SEL_W'(1) : slot;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: frame-sync locked demux of a serial TDM stream into N_CH-bit words
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [N_CH-1:0]  out,
  output logic             frame_valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err
);
  state_t state;
  logic [N_CH-1:0] shadow;
  logic [MISS_W-1:0] miss_cnt;
  logic misalign, lost, cnt_en, load1, clr, wrap;
  assign misalign = state == LOCKED && sync && slot != '0;
  assign lost = state == LOCKED && !sync && slot == '0 && miss_cnt + MISS_W'(1) == MISS_W'(MISS_MAX);
  assign load1 = en && sync && (state == HUNT || misalign);
  assign clr = en && lost;
  assign cnt_en = en && state == LOCKED;
  tdm_slot_counter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_cnt (
    .clk(clk), .rst(rst), .en(cnt_en), .load1(load1), .clr(clr), .slot(slot), .wrap(wrap)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      shadow <= '0;
      out <= '0;
      miss_cnt <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
      locked <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
      if (en && state == HUNT && sync) begin
        state <= LOCKED;
        locked <= 1'b1;
        shadow <= N_CH'(din);
        miss_cnt <= '0;
      end else if (en && misalign) begin
        sync_err <= 1'b1;
        shadow <= N_CH'(din);
        miss_cnt <= '0;
      end else if (en && lost) begin
        state <= HUNT;
        locked <= 1'b0;
        sync_err <= 1'b1;
        shadow <= '0;
        miss_cnt <= '0;
      end else if (cnt_en) begin
        if (slot == '0)
          miss_cnt <= sync ? '0 : (&miss_cnt) ? miss_cnt : miss_cnt + MISS_W'(1);
        shadow[slot] <= din;
        if (wrap) begin
          out <= {din, shadow[N_CH-2:0]};
          frame_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: random and directed stimulus against a slot-level frame model with a scoreboard
module tb_tdm_demux4;
  localparam int MISS_MAX = 2;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, din = 1'b0, sync = 1'b0;
  logic [3:0] out;
  logic frame_valid, locked, sync_err;
  logic [1:0] slot;
  typedef struct packed {
    logic [3:0] o;
    logic fv;
    logic se;
    logic [1:0] sl;
    logic lk;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit m_lk = 0;
  int m_pos = 0, m_miss = 0;
  bit m_bits[4];
  logic [3:0] m_out = '0;

  tdm_demux4 #(.N_CH(4), .SEL_W(2), .MISS_MAX(MISS_MAX)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync), .out(out),
    .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_out", int'(out), int'(e.o));
      chk("sb_frame_valid", int'(frame_valid), int'(e.fv));
      chk("sb_sync_err", int'(sync_err), int'(e.se));
      chk("sb_slot", int'(slot), int'(e.sl));
      chk("sb_locked", int'(locked), int'(e.lk));
    end
  end

  task automatic restart(input bit d);
    foreach (m_bits[k]) m_bits[k] = 0;
    m_bits[0] = d;
    m_pos = 1;
    m_miss = 0;
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic d);
    bit fv, se;
    rst = r; en = e; sync = s; din = d;
    @(posedge clk);
    fv = 0; se = 0;
    if (r) begin
      m_lk = 0; m_pos = 0; m_miss = 0; m_out = '0;
      foreach (m_bits[k]) m_bits[k] = 0;
    end else if (e) begin
      if (!m_lk) begin
        if (s) begin m_lk = 1; restart(d); end
      end else if (s && m_pos != 0) begin
        se = 1; restart(d);
      end else if (!s && m_pos == 0 && m_miss + 1 == MISS_MAX) begin
        se = 1; m_lk = 0; m_pos = 0; m_miss = 0;
        foreach (m_bits[k]) m_bits[k] = 0;
      end else begin
        if (m_pos == 0) m_miss = s ? 0 : m_miss + 1;
        m_bits[m_pos] = d;
        if (m_pos == 3) begin
          foreach (m_bits[k]) m_out[k] = m_bits[k];
          fv = 1;
          m_pos = 0;
        end else m_pos++;
      end
    end
    q.push_back('{o: m_out, fv: fv, se: se, sl: 2'(m_pos), lk: m_lk});
    #1;
  endtask

  task automatic frame(input logic [3:0] data, input bit s0, input int gap);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, s0 && k == 0, data[k]);
      if (k < 3 || gap > 0) repeat (gap) step(0, 0, 0, 0);
    end
  endtask

  initial begin
    int tx = 0;
    bit r, e, s, d;
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("reset_out", out, 0);
    chk("reset_locked", locked, 0);
    chk("reset_slot", slot, 0);
    chk("reset_fv", frame_valid, 0);
    frame(4'b1010, 1, 0);
    chk("basic_out", out, 4'b1010);
    chk("basic_fv", frame_valid, 1);
    chk("basic_slot", slot, 0);
    chk("basic_locked", locked, 1);
    step(0, 0, 0, 0);
    chk("basic_fv_pulse", frame_valid, 0);
    frame(4'b1010, 1, 3);
    chk("gap_out", out, 4'b1010);
    chk("gap_slot", slot, 0);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    chk("mis_err", sync_err, 1);
    chk("mis_slot", slot, 1);
    chk("mis_fv", frame_valid, 0);
    repeat (3) step(0, 1, 0, 1);
    chk("mis_out", out, 4'b1110);
    frame(4'b1100, 0, 0);
    chk("fly_out", out, 4'b1100);
    chk("fly_locked", locked, 1);
    step(0, 1, 0, 0);
    chk("lol_err", sync_err, 1);
    chk("lol_locked", locked, 0);
    chk("lol_out", out, 4'b1100);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("rst_mid_slot", slot, 0);
    chk("rst_mid_out", out, 0);
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_fv", frame_valid, 0);
    frame(4'hF, 1, 0);
    chk("rst_new_out", out, 4'hF);
    frame(4'h1, 1, 0);
    chk("b2b_out1", out, 4'h1);
    chk("b2b_fv1", frame_valid, 1);
    frame(4'h8, 1, 0);
    chk("b2b_out2", out, 4'h8);
    chk("b2b_err2", sync_err, 0);
    frame(4'h5, 1, 0);
    chk("b2b_out3", out, 4'h5);
    chk("b2b_fv3", frame_valid, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 299) == 0;
      e = $urandom_range(0, 3) != 0;
      s = (tx == 0) ^ ($urandom_range(0, 15) == 0);
      d = 1'($urandom);
      step(r, e, s, d);
      tx = r ? 0 : e ? (tx + 1) % 4 : tx;
    end
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 select tree.
- A 4:1 mux stepped through sel = 0,1,2,3 produces a serial time-division stream. This block recovers the four parallel bits from that stream.
- Locks to a frame-sync marker, tracks the slot index, and presents each completed 4-bit frame as a registered word with a one-cycle valid pulse.
- Sits directly downstream of the serial mux output in the datapath.

Parameters:
- N_CH, 4, channels (slots) per frame; must be a power of 2, ≥ 2.
- SEL_W, 2, slot index width, equal to log2(N_CH).
- MISS_MAX, 2, consecutive missing sync markers at slot 0 before loss of lock; range 1–7.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  slot strobe; din/sync are sampled only on cycles with en=1.
- din  input  1  serial TDM data bit for the current slot.
- sync  input  1  frame marker; asserted together with the slot-0 bit.
- out  output  N_CH  last completed frame; out[k] = bit received in slot k.
- frame_valid  output  1  one-cycle pulse; out was updated on this edge.
- slot  output  SEL_W  slot index expected for the next en cycle.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a misplaced sync or on loss of lock.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-frame):
  - state=HUNT; slot=0; shadow=0; out=0; miss_cnt=0.
  - frame_valid=0; sync_err=0; locked=0.
  - Reset overrides en/sync in the same cycle.
- en=0: all state, slot, shadow and out hold. frame_valid and sync_err are 0 the next cycle.
- HUNT:
  - en&sync: shadow[0]=din; slot=1; state=LOCKED; miss_cnt=0.
  - Any other input is ignored; out holds.
- LOCKED, en=1, rules evaluated in priority order:
  1. sync=1 and slot≠0 (misaligned): sync_err=1; shadow cleared, then shadow[0]=din; slot=1; miss_cnt=0; no frame_valid. The partial frame is discarded.
  2. sync=1 and slot=0: miss_cnt=0; capture normally.
  3. sync=0 and slot=0 (flywheel):
     - If miss_cnt+1 = MISS_MAX: state=HUNT; sync_err=1; slot=0; shadow=0; no capture.
     - Otherwise miss_cnt+=1 and capture normally.
  4. Normal capture: shadow[slot]=din.
     - If slot=N_CH-1: out={din, shadow[N_CH-2:0]}; frame_valid=1; slot=0 (wrap).
     - Otherwise slot+=1.
- Latency: out and frame_valid change on the same edge that samples the slot N_CH-1 bit. frame_valid is high for exactly one cycle.
- out holds its last frame through HUNT and through loss of lock; only reset clears it.
- locked is registered and reflects state after the edge.
- Widths:
  - slot wraps modulo N_CH.
  - miss_cnt is 3 bits and saturates; it never wraps.
  - The counter never exceeds MISS_MAX.
- The en=1 and sync=1 case is fully determined by the rules above. There is no separate simultaneous-event case.

Decomposition:
- Package tdm_pkg:
  - N_CH/SEL_W defaults.
  - State enum {HUNT, LOCKED}.
  - MISS_W=3 constant.
- One natural sub-module, tdm_slot_counter:
  - Inputs: clk, rst, en, load1, clr.
  - Outputs: slot, wrap (slot=N_CH-1 & en).
  - Handles increment/wrap/realign.
- The FSM, shadow register and output register live in tdm_demux4.

Test Plan:
- Basic frame: reset, then 4 en cycles with (sync,din) = (1,0),(0,1),(0,0),(0,1) → after the 4th edge out=4'b1010, frame_valid=1 for one cycle, slot=0, locked=1.
- Gapped strobe: the same frame with en=0 for 3 cycles between each slot → identical out=4'b1010; out, slot and frame_valid do not change during the gaps.
- Misaligned sync: locked; slots 0,1 sent (din 1,1); then sync=1 with din=0 at slot 2 → sync_err pulse, slot=1, no frame_valid. The next 3 slots with din 1,1,1 → out=4'b1110.
- Flywheel and loss of lock (MISS_MAX=2):
  - Frame with no sync at slot 0, din 0,0,1,1 → out=4'b1100, locked stays 1.
  - Next frame also without sync → sync_err pulse at slot 0, locked=0, out still 4'b1100.
- Reset mid-frame: rst=1 after slot 2 of a frame → next cycle slot=0, out=0, locked=0, frame_valid=0. A new sync frame 1,1,1,1 (sync on the first) → out=4'b1111.
- Back-to-back frames: 3 frames with sync every 4th en, data 0x1, 0x8, 0x5 → three frame_valid pulses 4 cycles apart, out=0x1, 0x8, 0x5, sync_err never asserted.
